// File: rtl/scr1_dmi_scan_chain.sv
// DTMCS/DMI data registers in the system clock domain; launches DM requests over req/ack.
// Latency: ch_tdo one cycle after capture/shift; dmi_req one cycle after update; dmi_req drops one cycle after ack.
// Backpressure: one request outstanding; DMI accesses while busy are refused and flagged sticky until dmireset.
module scr1_dmi_scan_chain #(
    parameter int DMI_ABITS   = 7,
    parameter int DTM_VERSION = 1
) (
    input  logic                 clk,
    input  logic                 trst_n,
    input  logic                 ch_sel,
    input  logic [1:0]           ch_id,
    input  logic                 ch_capture,
    input  logic                 ch_shift,
    input  logic                 ch_update,
    input  logic                 ch_tdi,
    output logic                 ch_tdo,
    output logic                 dmi_req,
    output logic                 dmi_wr,
    output logic [DMI_ABITS-1:0] dmi_addr,
    output logic [31:0]          dmi_wdata,
    input  logic                 dmi_ack,
    input  logic [31:0]          dmi_rdata
);

    localparam int SR_W = DMI_ABITS + 34;

    typedef enum logic {IDLE, REQ} state_t;

    state_t                state_q, state_nxt;
    logic [SR_W-1:0]       sr, sr_nxt;
    logic [DMI_ABITS-1:0]  addr_q;
    logic [31:0]           data_q;
    logic                  sticky_busy;
    logic                  drop_q;

    logic                  act, sel_dtmcs, sel_dmi;
    logic                  do_cap, do_shift, do_upd;
    logic                  upd_dtmcs, upd_dmi, launch, ack;
    logic [1:0]            upd_op, cap_op, dmistat;
    logic [31:0]           dtmcs_val;
    logic [DMI_ABITS-1:0]  upd_addr;

    assign act       = ch_sel && (ch_id == 2'd0 || ch_id == 2'd1);
    assign sel_dtmcs = (ch_id == 2'd0);
    assign sel_dmi   = (ch_id == 2'd1);
    assign do_cap    = act && ch_capture;
    assign do_shift  = act && !ch_capture && ch_shift;
    assign do_upd    = act && !ch_capture && !ch_shift && ch_update;
    assign upd_dtmcs = do_upd && sel_dtmcs;
    assign upd_dmi   = do_upd && sel_dmi;

    assign upd_op   = sr[1:0];
    assign upd_addr = sr[SR_W-1:34];
    assign launch   = upd_dmi && !sticky_busy && (state_q == IDLE)
                      && (upd_op == 2'd1 || upd_op == 2'd2);
    assign ack      = (state_q == REQ) && dmi_ack;

    assign dmistat   = sticky_busy ? 2'b11 : 2'b00;
    assign cap_op    = (sticky_busy || state_q == REQ) ? 2'b11 : 2'b00;
    assign dtmcs_val = {14'b0, 2'b0, 1'b0, 3'd1, dmistat, 6'(DMI_ABITS), 4'(DTM_VERSION)};

    always_comb begin
        sr_nxt = sr;
        if (do_cap) begin
            if (sel_dtmcs) begin
                sr_nxt       = '0;
                sr_nxt[31:0] = dtmcs_val;
            end else begin
                sr_nxt = {addr_q, data_q, cap_op};
            end
        end else if (do_shift) begin
            if (sel_dtmcs) sr_nxt[31:0] = {ch_tdi, sr[31:1]};
            else           sr_nxt       = {ch_tdi, sr[SR_W-1:1]};
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (launch) state_nxt = REQ;
            REQ:     if (dmi_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge trst_n) begin
        if (!trst_n) begin
            state_q     <= IDLE;
            sr          <= '0;
            ch_tdo      <= 1'b0;
            dmi_req     <= 1'b0;
            dmi_wr      <= 1'b0;
            dmi_addr    <= '0;
            dmi_wdata   <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            sticky_busy <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q <= state_nxt;

            if (do_cap || do_shift) begin
                sr     <= sr_nxt;
                ch_tdo <= sr_nxt[0];
            end

            if (launch) begin
                addr_q    <= upd_addr;
                dmi_addr  <= upd_addr;
                dmi_wdata <= sr[33:2];
                dmi_wr    <= (upd_op == 2'd2);
                dmi_req   <= 1'b1;
                if (upd_op == 2'd2) data_q <= sr[33:2];
            end else if (ack) begin
                dmi_req <= 1'b0;
                if (!dmi_wr && !drop_q) data_q <= dmi_rdata;
            end

            if (upd_dtmcs && (sr[16] || sr[17]))
                sticky_busy <= 1'b0;
            else if (state_q == REQ && ((do_cap && sel_dmi) || (upd_dmi && !sticky_busy)))
                sticky_busy <= 1'b1;

            // A hard reset cannot abort the handshake, so it only discards the pending read data.
            if (ack)
                drop_q <= 1'b0;
            else if (upd_dtmcs && sr[17] && state_q == REQ)
                drop_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_scr1_dmi_scan_chain.sv
// Directed bench for scr1_dmi_scan_chain: scans DTMCS/DMI, drives the DM handshake, checks against hand-computed values.
module tb_scr1_dmi_scan_chain;

    localparam int L = 41;

    logic        clk = 1'b0;
    logic        trst_n = 1'b0;
    logic        ch_sel = 1'b0;
    logic [1:0]  ch_id = 2'd0;
    logic        ch_capture = 1'b0;
    logic        ch_shift = 1'b0;
    logic        ch_update = 1'b0;
    logic        ch_tdi = 1'b0;
    logic        ch_tdo;
    logic        dmi_req;
    logic        dmi_wr;
    logic [6:0]  dmi_addr;
    logic [31:0] dmi_wdata;
    logic        dmi_ack = 1'b0;
    logic [31:0] dmi_rdata = '0;

    int checks = 0;
    int errors = 0;

    scr1_dmi_scan_chain #(.DMI_ABITS(7), .DTM_VERSION(1)) dut (
        .clk        (clk),
        .trst_n     (trst_n),
        .ch_sel     (ch_sel),
        .ch_id      (ch_id),
        .ch_capture (ch_capture),
        .ch_shift   (ch_shift),
        .ch_update  (ch_update),
        .ch_tdi     (ch_tdi),
        .ch_tdo     (ch_tdo),
        .dmi_req    (dmi_req),
        .dmi_wr     (dmi_wr),
        .dmi_addr   (dmi_addr),
        .dmi_wdata  (dmi_wdata),
        .dmi_ack    (dmi_ack),
        .dmi_rdata  (dmi_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic cap, input logic sh, input logic upd, input logic tdi,
                          input logic sel, input logic [1:0] id);
        @(negedge clk);
        ch_sel = sel; ch_id = id; ch_capture = cap; ch_shift = sh; ch_update = upd; ch_tdi = tdi;
        @(posedge clk); #1;
        ch_capture = 1'b0; ch_shift = 1'b0; ch_update = 1'b0; ch_tdi = 1'b0;
    endtask

    // Capture, then shift len bits of din LSB-first while collecting the captured value from ch_tdo.
    task automatic scan(input logic sel, input logic [1:0] id, input int len,
                        input logic [L-1:0] din, input logic upd, output logic [L-1:0] dout);
        dout = '0;
        strobe(1'b1, 1'b0, 1'b0, 1'b0, sel, id);
        dout[0] = ch_tdo;
        for (int i = 0; i < len; i++) begin
            strobe(1'b0, 1'b1, 1'b0, din[i], sel, id);
            if (i < len - 1) dout[i+1] = ch_tdo;
        end
        if (upd) strobe(1'b0, 1'b0, 1'b1, 1'b0, sel, id);
    endtask

    task automatic do_ack(input logic [31:0] rd, input int delay);
        int n = 0;
        while (!dmi_req && n < 100) begin @(posedge clk); #1; n++; end
        check("req_before_ack", {63'b0, dmi_req}, 64'd1);
        repeat (delay) begin @(posedge clk); #1; end
        @(negedge clk);
        dmi_ack = 1'b1; dmi_rdata = rd;
        @(posedge clk); #1;
        dmi_ack = 1'b0; dmi_rdata = '0;
        check("req_drop", {63'b0, dmi_req}, 64'd0);
    endtask

    logic [L-1:0] o;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_tdo",   {63'b0, ch_tdo},  64'd0);
        check("rst_req",   {63'b0, dmi_req}, 64'd0);
        check("rst_wr",    {63'b0, dmi_wr},  64'd0);
        check("rst_addr",  {57'b0, dmi_addr}, 64'd0);
        check("rst_wdata", {32'b0, dmi_wdata}, 64'd0);
        @(negedge clk); trst_n = 1'b1;

        // DTMCS idcode-style readout
        scan(1'b1, 2'd0, 32, '0, 1'b0, o);
        check("dtmcs", {32'b0, o[31:0]}, 64'h1071);

        // Write 0x1 to 0x10
        scan(1'b1, 2'd1, L, {7'h10, 32'h1, 2'd2}, 1'b1, o);
        check("wr_req",   {63'b0, dmi_req}, 64'd1);
        check("wr_wr",    {63'b0, dmi_wr},  64'd1);
        check("wr_addr",  {57'b0, dmi_addr}, 64'h10);
        check("wr_wdata", {32'b0, dmi_wdata}, 64'h1);
        do_ack(32'hFFFF_FFFF, 3);
        scan(1'b1, 2'd1, L, '0, 1'b1, o);
        check("wr_cap", {23'b0, o}, {23'b0, 7'h10, 32'h1, 2'd0});
        check("nop_no_req", {63'b0, dmi_req}, 64'd0);

        // Read from 0x11
        scan(1'b1, 2'd1, L, {7'h11, 32'h0, 2'd1}, 1'b1, o);
        check("rd_req",  {63'b0, dmi_req}, 64'd1);
        check("rd_wr",   {63'b0, dmi_wr},  64'd0);
        check("rd_addr", {57'b0, dmi_addr}, 64'h11);
        do_ack(32'hDEAD_BEEF, 0);
        scan(1'b1, 2'd1, L, '0, 1'b0, o);
        check("rd_cap", {23'b0, o}, {23'b0, 7'h11, 32'hDEAD_BEEF, 2'd0});

        // Busy: capture during outstanding request, ignored update, dmireset
        scan(1'b1, 2'd1, L, {7'h20, 32'h0, 2'd1}, 1'b1, o);
        scan(1'b1, 2'd1, L, {7'h21, 32'h9, 2'd2}, 1'b1, o);
        check("busy_cap", {23'b0, o}, {23'b0, 7'h20, 32'hDEAD_BEEF, 2'd3});
        check("busy_addr", {57'b0, dmi_addr}, 64'h20);
        check("busy_wr",   {63'b0, dmi_wr},  64'd0);
        do_ack(32'h55, 1);
        repeat (3) begin @(posedge clk); #1; end
        check("no_second_req", {63'b0, dmi_req}, 64'd0);
        scan(1'b1, 2'd1, L, '0, 1'b0, o);
        check("sticky_cap", {23'b0, o}, {23'b0, 7'h20, 32'h55, 2'd3});
        scan(1'b1, 2'd0, 32, 41'h1_0000, 1'b1, o);
        check("dtmcs_busy", {32'b0, o[31:0]}, 64'h1C71);
        scan(1'b1, 2'd1, L, '0, 1'b0, o);
        check("dmireset_cap", {23'b0, o}, {23'b0, 7'h20, 32'h55, 2'd0});

        // Hard reset during a read discards the returned data
        scan(1'b1, 2'd1, L, {7'h30, 32'h0, 2'd1}, 1'b1, o);
        check("hr_req", {63'b0, dmi_req}, 64'd1);
        scan(1'b1, 2'd0, 32, 41'h2_0000, 1'b1, o);
        check("hr_req_held", {63'b0, dmi_req}, 64'd1);
        do_ack(32'h1234_5678, 2);
        scan(1'b1, 2'd1, L, '0, 1'b0, o);
        check("hr_cap", {23'b0, o}, {23'b0, 7'h30, 32'h55, 2'd0});

        // Deselected / unsupported chain: strobes have no effect
        scan(1'b0, 2'd1, L, {7'h40, 32'h1, 2'd2}, 1'b1, o);
        check("nosel_req", {63'b0, dmi_req}, 64'd0);
        scan(1'b1, 2'd2, L, {7'h41, 32'h2, 2'd2}, 1'b1, o);
        check("id2_req", {63'b0, dmi_req}, 64'd0);
        scan(1'b1, 2'd1, L, '0, 1'b0, o);
        check("ignored_cap", {23'b0, o}, {23'b0, 7'h30, 32'h55, 2'd0});

        // Asynchronous reset with a request outstanding
        scan(1'b1, 2'd1, L, {7'h50, 32'h0, 2'd1}, 1'b1, o);
        check("ar_req", {63'b0, dmi_req}, 64'd1);
        check("ar_tdo", {63'b0, ch_tdo},  64'd1);
        #2 trst_n = 1'b0;
        #1;
        check("ar_req_low", {63'b0, dmi_req}, 64'd0);
        check("ar_tdo_low", {63'b0, ch_tdo},  64'd0);
        check("ar_addr",    {57'b0, dmi_addr}, 64'd0);
        @(negedge clk); trst_n = 1'b1;
        scan(1'b1, 2'd1, L, '0, 1'b0, o);
        check("ar_cap", {23'b0, o}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
